reg_file_mp: RTL

Parametrised multi-read-port integer register file for the RISC-V single-cycle core. It replaces the fixed 32x32, two-read-port register file. It adds:
- configurable width, depth and read-port count;
- same-cycle write-to-read bypass;
- a sequential clear engine that zeroes the whole file on request without a global reset.

It sits between the decode stage (read addresses) and the writeback path (write port).

---
 rtl/reg_file_mp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// ============================================================================
// reg_file_mp : multi-read-port register file with write bypass and clear engine
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_file_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            WE3,
  input  logic [$clog2(NREGS)-1:0]        A3,
  input  logic [XLEN-1:0]                 WD3,
  input  logic [NRD*$clog2(NREGS)-1:0]    RA,
  output logic [NRD*XLEN-1:0]             RD,
  input  logic                            clr_req,
  output logic                            busy,
  output logic                            wr_drop
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            wr_drop_q, wr_drop_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic wr_hit;
  logic wr_en;

  assign wr_hit = WE3 && (A3 != '0);
  assign wr_en  = wr_hit && !busy;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; clr_req is only looked at from IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from registered state
  always_comb begin
    busy    = (state_q == ST_CLEAR);
    wr_drop = wr_drop_q;
  end

  // Storage; writes and clearing never coincide because writes need busy=0
  always_comb begin
    regs_d = regs_q;
    if (busy) begin
      regs_d[cnt_q] = '0;
    end
    if (wr_en) begin
      regs_d[A3] = WD3;
    end
    regs_d[0] = '0;
  end

  assign wr_drop_d = wr_hit && busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_drop_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  generate
    for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = RA[p*AW +: AW];
      assign RD[p*XLEN +: XLEN] = (ra == '0)                ? '0  :
                                  (wr_en && (A3 == ra))     ? WD3 :
                                  regs_q[ra];
    end
  endgenerate

endmodule

`default_nettype wire
